// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared hazard controller types and constants
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MISS_WAIT = 2'd1,
        MUL_WAIT  = 2'd2
    } hz_state_e;

    localparam int MUL_LATENCY_DEFAULT = 5;

    // Bubble opcode that Decode inserts when a stage register is flushed.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic int mul_cnt_width(input int latency);
        return (latency > 2) ? $clog2(latency - 1) : 1;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline status inputs and stage enable/flush outputs
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_addr_a;
    logic [REG_ADDR_W-1:0] id_addr_b;
    logic                  id_use_a;
    logic                  id_use_b;
    logic                  ex_load_instr;
    logic                  ex_write;
    logic [REG_ADDR_W-1:0] ex_addr_d;
    logic                  ex_mul_instr;
    logic                  ex_branch_taken;
    logic                  mem_req;
    logic                  mem_miss;
    logic                  mem_ready;

    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
    logic busy;

    modport master (
        output id_valid, id_addr_a, id_addr_b, id_use_a, id_use_b,
               ex_load_instr, ex_write, ex_addr_d, ex_mul_instr, ex_branch_taken,
               mem_req, mem_miss, mem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, busy
    );

    modport slave (
        input  id_valid, id_addr_a, id_addr_b, id_use_a, id_use_b,
               ex_load_instr, ex_write, ex_addr_d, ex_mul_instr, ex_branch_taken,
               mem_req, mem_miss, mem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, busy
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_mul_stall_counter.sv
// rtl/pipeline_hazard_ctrl_mul_stall_counter.sv - MUL occupancy down-counter with zero flag
module mul_stall_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer; HAZARD_PERF_CNT_EN adds perf counters
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEFAULT
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    pipeline_hazard_ctrl_if.slave   bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]        stall_cycles,
    output logic [CNT_W-1:0]        flush_count
`endif
);

    localparam int              MUL_CNT_W  = mul_cnt_width(MUL_LATENCY);
    localparam bit              MUL_STALLS = (MUL_LATENCY > 1);
    localparam logic [MUL_CNT_W-1:0] MUL_LOAD =
        MUL_CNT_W'((MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0);

    hz_state_e r_state;
    hz_state_e w_next;
    logic      w_miss;
    logic      w_load_use;
    logic      w_mul_load;
    logic      w_mul_dec;
    logic      w_cnt_zero;

    assign w_miss = bus.mem_req & bus.mem_miss;

    // Register 0 reads as zero, so a load targeting it never blocks a consumer.
    assign w_load_use = bus.id_valid & bus.ex_load_instr & bus.ex_write &
                        (bus.ex_addr_d != '0) &
                        (((bus.ex_addr_d == bus.id_addr_a) & bus.id_use_a) |
                         ((bus.ex_addr_d == bus.id_addr_b) & bus.id_use_b));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        w_mul_load       = 1'b0;
        w_mul_dec        = 1'b0;
        bus.pc_en        = 1'b1;
        bus.if_id_en     = 1'b1;
        bus.id_ex_en     = 1'b1;
        bus.ex_mem_en    = 1'b1;
        bus.mem_wb_en    = 1'b1;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_flush  = 1'b0;
        bus.ex_mem_flush = 1'b0;
        bus.mem_wb_flush = 1'b0;
        bus.busy         = (r_state != RUN);

        if (reset) begin
            w_next           = RUN;
            bus.pc_en        = 1'b0;
            bus.if_id_en     = 1'b0;
            bus.id_ex_en     = 1'b0;
            bus.ex_mem_en    = 1'b0;
            bus.mem_wb_en    = 1'b0;
            bus.if_id_flush  = 1'b1;
            bus.id_ex_flush  = 1'b1;
            bus.ex_mem_flush = 1'b1;
            bus.mem_wb_flush = 1'b1;
            bus.busy         = 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_miss) begin
                        bus.pc_en        = 1'b0;
                        bus.if_id_en     = 1'b0;
                        bus.id_ex_en     = 1'b0;
                        bus.ex_mem_en    = 1'b0;
                        bus.mem_wb_flush = 1'b1;
                        if (!bus.mem_ready) begin
                            w_next = MISS_WAIT;
                        end
                    end else if (bus.ex_branch_taken) begin
                        bus.if_id_flush = 1'b1;
                        bus.id_ex_flush = 1'b1;
                    end else if (MUL_STALLS && bus.ex_mul_instr) begin
                        bus.pc_en        = 1'b0;
                        bus.if_id_en     = 1'b0;
                        bus.id_ex_en     = 1'b0;
                        bus.ex_mem_flush = 1'b1;
                        w_mul_load       = 1'b1;
                        w_next           = MUL_WAIT;
                    end else if (w_load_use) begin
                        bus.pc_en       = 1'b0;
                        bus.if_id_en    = 1'b0;
                        bus.id_ex_flush = 1'b1;
                    end
                end
                MISS_WAIT: begin
                    if (bus.mem_ready) begin
                        w_next = RUN;
                    end else begin
                        bus.pc_en        = 1'b0;
                        bus.if_id_en     = 1'b0;
                        bus.id_ex_en     = 1'b0;
                        bus.ex_mem_en    = 1'b0;
                        bus.mem_wb_flush = 1'b1;
                    end
                end
                MUL_WAIT: begin
                    // The release cycle advances EX, so the same MUL cannot retrigger.
                    if (w_cnt_zero) begin
                        w_next = RUN;
                    end else begin
                        bus.pc_en        = 1'b0;
                        bus.if_id_en     = 1'b0;
                        bus.id_ex_en     = 1'b0;
                        bus.ex_mem_flush = 1'b1;
                        w_mul_dec        = 1'b1;
                    end
                end
                default: begin
                    w_next = RUN;
                end
            endcase
        end
    end

    mul_stall_counter #(
        .W (MUL_CNT_W)
    ) u_mul_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_mul_load),
        .i_load_val (MUL_LOAD),
        .i_dec      (w_mul_dec),
        .o_zero     (w_cnt_zero)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic w_branch_flush;

    assign w_branch_flush = (r_state == RUN) & ~w_miss & bus.ex_branch_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!bus.pc_en && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (w_branch_flush && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl (MUL_LATENCY 5 and 1)
module tb_pipeline_hazard_ctrl;

    // {pc, if_id, id_ex, ex_mem, mem_wb en, if_id, id_ex, ex_mem, mem_wb flush, busy}
    localparam logic [9:0] E_RESET    = 10'b00000_1111_0;
    localparam logic [9:0] E_RUN      = 10'b11111_0000_0;
    localparam logic [9:0] E_LU       = 10'b00111_0100_0;
    localparam logic [9:0] E_BR       = 10'b11111_1100_0;
    localparam logic [9:0] E_MUL_RUN  = 10'b00011_0010_0;
    localparam logic [9:0] E_MUL_WAIT = 10'b00011_0010_1;
    localparam logic [9:0] E_REL      = 10'b11111_0000_1;
    localparam logic [9:0] E_MISS_RUN = 10'b00001_0001_0;
    localparam logic [9:0] E_MISS_WT  = 10'b00001_0001_1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       id_valid, id_use_a, id_use_b, ex_load_instr, ex_write;
    logic [4:0] id_addr_a, id_addr_b, ex_addr_d;
    logic       ex_mul_instr, ex_branch_taken, mem_req, mem_miss, mem_ready;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] q_e5[$];
    logic [9:0] q_e1[$];
    string      q_tag[$];

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(5)) bus5 ();
    pipeline_hazard_ctrl_if #(.REG_ADDR_W(5)) bus1 ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall5, flush5, stall1, flush1;
`endif

    pipeline_hazard_ctrl #(.MUL_LATENCY(5)) u_dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus5)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles (stall5),
        .flush_count  (flush5)
`endif
    );

    pipeline_hazard_ctrl #(.MUL_LATENCY(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles (stall1),
        .flush_count  (flush1)
`endif
    );

    logic [9:0] obs5, obs1;
    assign obs5 = {bus5.pc_en, bus5.if_id_en, bus5.id_ex_en, bus5.ex_mem_en, bus5.mem_wb_en,
                   bus5.if_id_flush, bus5.id_ex_flush, bus5.ex_mem_flush, bus5.mem_wb_flush,
                   bus5.busy};
    assign obs1 = {bus1.pc_en, bus1.if_id_en, bus1.id_ex_en, bus1.ex_mem_en, bus1.mem_wb_en,
                   bus1.if_id_flush, bus1.id_ex_flush, bus1.ex_mem_flush, bus1.mem_wb_flush,
                   bus1.busy};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_use_a = 0; id_use_b = 0; ex_load_instr = 0; ex_write = 0;
        id_addr_a = 0; id_addr_b = 0; ex_addr_d = 0;
        ex_mul_instr = 0; ex_branch_taken = 0; mem_req = 0; mem_miss = 0; mem_ready = 0;
    endtask

    task automatic drive();
        bus5.id_valid = id_valid;   bus1.id_valid = id_valid;
        bus5.id_addr_a = id_addr_a; bus1.id_addr_a = id_addr_a;
        bus5.id_addr_b = id_addr_b; bus1.id_addr_b = id_addr_b;
        bus5.id_use_a = id_use_a;   bus1.id_use_a = id_use_a;
        bus5.id_use_b = id_use_b;   bus1.id_use_b = id_use_b;
        bus5.ex_load_instr = ex_load_instr; bus1.ex_load_instr = ex_load_instr;
        bus5.ex_write = ex_write;   bus1.ex_write = ex_write;
        bus5.ex_addr_d = ex_addr_d; bus1.ex_addr_d = ex_addr_d;
        bus5.ex_mul_instr = ex_mul_instr; bus1.ex_mul_instr = ex_mul_instr;
        bus5.ex_branch_taken = ex_branch_taken; bus1.ex_branch_taken = ex_branch_taken;
        bus5.mem_req = mem_req;     bus1.mem_req = mem_req;
        bus5.mem_miss = mem_miss;   bus1.mem_miss = mem_miss;
        bus5.mem_ready = mem_ready; bus1.mem_ready = mem_ready;
    endtask

    task automatic step(input string tag, input logic [9:0] e5, input logic [9:0] e1);
        drive();
        q_e5.push_back(e5);
        q_e1.push_back(e1);
        q_tag.push_back(tag);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q_e5.size() > 0) begin
            logic [9:0] e5, e1;
            string      tg;
            e5 = q_e5.pop_front();
            e1 = q_e1.pop_front();
            tg = q_tag.pop_front();
            check({tg, "_lat5"}, {22'd0, obs5}, {22'd0, e5});
            check({tg, "_lat1"}, {22'd0, obs1}, {22'd0, e1});
        end
    end

    initial begin
        clear_inputs();
        reset = 1;
        step("reset0", E_RESET, E_RESET);
        step("reset1", E_RESET, E_RESET);
        reset = 0;
        step("idle", E_RUN, E_RUN);

        ex_load_instr = 1; ex_write = 1; ex_addr_d = 3; id_valid = 1;
        id_addr_a = 3; id_use_a = 1;
        step("lu_a", E_LU, E_LU);
        clear_inputs();
        step("lu_after", E_RUN, E_RUN);
        ex_load_instr = 1; ex_write = 1; ex_addr_d = 3; id_valid = 1; id_addr_a = 3;
        step("lu_nouse", E_RUN, E_RUN);
        ex_addr_d = 0; id_addr_a = 0; id_use_a = 1;
        step("lu_r0", E_RUN, E_RUN);
        ex_addr_d = 7; id_addr_a = 1; id_use_a = 1; id_addr_b = 7; id_use_b = 1;
        step("lu_b", E_LU, E_LU);
        clear_inputs();

        ex_mul_instr = 1;
        step("mul_c1", E_MUL_RUN, E_RUN);
        for (int i = 0; i < 3; i++) step($sformatf("mul_wait%0d", i), E_MUL_WAIT, E_RUN);
        step("mul_rel", E_REL, E_RUN);
        clear_inputs();
        step("mul_after", E_RUN, E_RUN);

        mem_req = 1; mem_miss = 1;
        step("miss_c1", E_MISS_RUN, E_MISS_RUN);
        for (int i = 0; i < 5; i++) step($sformatf("miss_wait%0d", i), E_MISS_WT, E_MISS_WT);
        mem_ready = 1;
        step("miss_rel", E_REL, E_REL);
        clear_inputs();
        step("miss_after", E_RUN, E_RUN);

        mem_req = 1; mem_miss = 1; mem_ready = 1;
        step("miss_fast", E_MISS_RUN, E_MISS_RUN);
        clear_inputs();
        step("miss_fast_after", E_RUN, E_RUN);

        mem_req = 1; mem_miss = 1; ex_branch_taken = 1; ex_mul_instr = 1;
        step("combo_c1", E_MISS_RUN, E_MISS_RUN);
        step("combo_wait", E_MISS_WT, E_MISS_WT);
        mem_ready = 1;
        step("combo_rel", E_REL, E_REL);
        clear_inputs();
        ex_branch_taken = 1;
        step("combo_br", E_BR, E_BR);
        clear_inputs();
        step("combo_after", E_RUN, E_RUN);

        ex_branch_taken = 1; ex_load_instr = 1; ex_write = 1; ex_addr_d = 4;
        id_valid = 1; id_addr_a = 4; id_use_a = 1;
        step("br_over_lu", E_BR, E_BR);
        clear_inputs();

        ex_mul_instr = 1;
        step("rmul_c1", E_MUL_RUN, E_RUN);
        step("rmul_wait", E_MUL_WAIT, E_RUN);
        reset = 1;
        step("rmul_reset", E_RESET, E_RESET);
        reset = 0; clear_inputs();
        step("rmul_after", E_RUN, E_RUN);
        step("rmul_after2", E_RUN, E_RUN);

`ifdef HAZARD_PERF_CNT_EN
        reset = 1;
        step("perf_reset", E_RESET, E_RESET);
        reset = 0;
        ex_load_instr = 1; ex_write = 1; ex_addr_d = 3; id_valid = 1; id_addr_a = 3; id_use_a = 1;
        step("perf_lu", E_LU, E_LU);
        clear_inputs();
        ex_branch_taken = 1;
        step("perf_br", E_BR, E_BR);
        clear_inputs();
        step("perf_idle", E_RUN, E_RUN);
        check("perf_stall5", stall5, 32'd1);
        check("perf_flush5", flush5, 32'd1);
        check("perf_stall1", stall1, 32'd1);
        check("perf_flush1", flush1, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline: IF, ID (Decode plus Registers_Bank), EX, MEM (MMU/cache) and WB.
- Watches the instruction in ID, the instruction in EX and the MEM access status.
- Drives a per-stage register enable and flush so that load-use hazards, multi-cycle MUL, cache misses and taken branches execute correctly.
- Owns the only pipeline FSM in the core.

Parameters:
- REG_ADDR_W, 5, register address width.
- MUL_LATENCY, 5, EX occupancy of a MUL in cycles (>=1; 1 means no stall).
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_addr_a  in  REG_ADDR_W  ID src1 register address
- id_addr_b  in  REG_ADDR_W  ID src2 register address
- id_use_a  in  1  ID instruction reads src1
- id_use_b  in  1  ID instruction reads src2 (low when y_sel selects immediate)
- ex_load_instr  in  1  EX instruction is a load
- ex_write  in  1  EX instruction writes a register
- ex_addr_d  in  REG_ADDR_W  EX destination register
- ex_mul_instr  in  1  EX instruction is a MUL
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- mem_req  in  1  MEM stage issues read_mmu or write_mmu this cycle
- mem_miss  in  1  cache miss on the current MEM access
- mem_ready  in  1  miss refill complete; data valid this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register load enables
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load a bubble (NOP, write_out=0, read/write_mmu=0)
- busy  out  1  FSM not in RUN

Behaviour:
- Clock `clk`; reset `reset`, synchronous and active-high.
- All outputs are combinational from the FSM state, the MUL counter and the inputs, with zero latency.
- Flush has priority over enable at each pipeline register.
- While reset=1: all *_en=0, all *_flush=1, busy=0. The next state is RUN and the counter is 0.
- A reset asserted in any state aborts that state with no residual stall.
- FSM states: RUN, MISS_WAIT, MUL_WAIT.
- RUN priority, highest first (default is all enables=1, all flushes=0):
  1. Miss: mem_req & mem_miss.
     - Freeze pc, IF/ID, ID/EX and EX/MEM (en=0).
     - mem_wb_flush=1.
     - Next state MISS_WAIT, or stay RUN if mem_ready is already 1 in the same cycle.
  2. Taken branch: ex_branch_taken.
     - if_id_flush=1 and id_ex_flush=1; pc_en=1 so the PC loads the target.
     - Any load-use or MUL condition in ID is ignored that cycle.
  3. MUL: ex_mul_instr and MUL_LATENCY>1.
     - pc_en=if_id_en=id_ex_en=0; ex_mem_flush=1.
     - Counter loads MUL_LATENCY-2; next state MUL_WAIT.
  4. Load-use: id_valid & ex_load_instr & ex_write & ex_addr_d!=0 & ((ex_addr_d==id_addr_a & id_use_a) | (ex_addr_d==id_addr_b & id_use_b)).
     - pc_en=if_id_en=0; id_ex_flush=1.
     - Lasts exactly one cycle.
     - Register 0 is hardwired zero and never creates a hazard.
- MISS_WAIT:
  - Same freeze as RUN case 1 while mem_ready=0.
  - On mem_ready=1: all enables=1 and go to RUN (the refilled access completes into MEM/WB that cycle).
  - ex_branch_taken and ex_mul_instr are ignored; they are re-evaluated in RUN after the release.
- MUL_WAIT:
  - Freeze as in RUN case 3.
  - When the counter is 0: release all enables and go to RUN. Otherwise decrement.
  - Total: MUL_LATENCY-1 stall cycles.
  - mem_miss is ignored here; MEM holds a bubble.
- A MUL stalled behind a miss is detected once the FSM is back in RUN. A MUL is never re-triggered, because the release cycle advances EX.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cycles and flush_count, each CNT_W bits.
  - stall_cycles increments every cycle with pc_en=0 outside reset.
  - flush_count increments once per taken-branch flush.
  - Both saturate at all-ones and clear on reset.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg holds:
  - the FSM state encoding (RUN=2'd0, MISS_WAIT=2'd1, MUL_WAIT=2'd2)
  - the default MUL_LATENCY constant
  - the NOP/bubble opcode constant shared with Decode.
- One sub-module, mul_stall_counter: load, decrement, zero flag.

Test Plan:
- ex_load_instr=1, ex_write=1, ex_addr_d=3, id_addr_a=3, id_use_a=1 -> exactly one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; no stall when ex_addr_d=0 or id_use_a=0.
- ex_mul_instr=1, MUL_LATENCY=5 -> 4 consecutive cycles of pc_en=0 with ex_mem_flush=1, busy=1 for cycles 2-4, then full release; MUL_LATENCY=1 -> no stall.
- mem_req=1, mem_miss=1, mem_ready rises 6 cycles later -> all upstream enables 0 and mem_wb_flush=1 for 6 cycles, enables=1 on the mem_ready cycle, then RUN.
- Same cycle miss + ex_branch_taken + ex_mul_instr -> miss handled first, then the branch flush after release, with no MUL stall unless ex_mul_instr is re-asserted.
- reset=1 during MUL_WAIT with counter=2 -> all flushes=1 and enables=0 that cycle, state RUN afterwards with no further stall.
- With HAZARD_PERF_CNT_EN: one load-use stall plus one taken branch -> stall_cycles=1, flush_count=1.
